// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised universal shift register.
// Supports hold, shift right, shift left and parallel load, each with serial
// in and out. A shift counter raises a one-cycle word-complete pulse (full)
// after WIDTH consecutive shifts. Left and right shifts both count toward the
// same total. A parallel load, a wrap or a reset clears the counter.
// Optional feature: define SHIFT_REG_ROTATE_EN to add the rot input. With
// rot=1, modes 01 and 10 rotate instead of shifting.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] pout_q, pout_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             full_q, full_d;
  logic             rot_en;
  logic             fill_r, fill_l;
  logic             shift;

`ifdef SHIFT_REG_ROTATE_EN
  assign rot_en = rot;
`else
  assign rot_en = 1'b0;
`endif

  // Rotation recirculates the outgoing bit; otherwise the serial inputs enter
  assign fill_r = rot_en ? pout_q[0]       : sin_r;
  assign fill_l = rot_en ? pout_q[WIDTH-1] : sin_l;

  // Next-state: data path operation plus the shift counter and word pulse
  always_comb begin
    pout_d = pout_q;
    cnt_d  = cnt_q;
    full_d = 1'b0;
    shift  = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          pout_d = pout_q;
        end
        MODE_RIGHT: begin
          pout_d = {fill_r, pout_q[WIDTH-1:1]};
          shift  = 1'b1;
        end
        MODE_LEFT: begin
          pout_d = {pout_q[WIDTH-2:0], fill_l};
          shift  = 1'b1;
        end
        MODE_LOAD: begin
          pout_d = pin;
          cnt_d  = '0;
        end
        default: begin
          pout_d = pout_q;
        end
      endcase
      if (shift) begin
        if (cnt_q == CNT_LAST) begin
          // Word complete: wrap with no gap so back-to-back words keep pace
          cnt_d  = '0;
          full_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
    end
  end

  // State registers; async active-low reset discards any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_q <= RESET_VAL;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      pout_q <= pout_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign pout   = pout_q;
  assign cnt    = cnt_q;
  assign full   = full_q;
  assign sout_r = pout_q[0];
  assign sout_l = pout_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Testbench for shift_reg_univ (WIDTH=8): directed scenarios plus random
// traffic. The stimulus process updates an arithmetic reference model and
// queues the expected post-edge state; a monitor pops and compares after
// every rising edge.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0]  pout;
    logic [CW-1:0] cnt;
    logic          full;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          rot = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic [W-1:0]  pin = '0;
  logic [W-1:0]  pout;
  logic          sout_r, sout_l;
  logic [CW-1:0] cnt;
  logic          full;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  // Reference model state: register value and shifts since last clear
  int m_val = 0;
  int m_cnt = 0;
  int m_full = 0;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
`ifdef SHIFT_REG_ROTATE_EN
    .rot    (rot),
`endif
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pin    (pin),
    .pout   (pout),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .full   (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pout = W'(m_val);
    e.cnt  = CW'(m_cnt);
    e.full = (m_full != 0);
    return e;
  endfunction

  // Apply one clock's worth of behaviour to the reference model
  task automatic model_step(input bit e, input bit [1:0] md, input bit sr,
                            input bit sl, input bit [W-1:0] p, input bit r);
    bit rot_on;
    bit shifted;
`ifdef SHIFT_REG_ROTATE_EN
    rot_on = r;
`else
    rot_on = 1'b0;
`endif
    shifted = 1'b0;
    m_full  = 0;
    if (e) begin
      if (md == 2'd1) begin
        m_val = (m_val / 2) + (rot_on ? (m_val % 2) : int'(sr)) * (1 << (W - 1));
        shifted = 1'b1;
      end else if (md == 2'd2) begin
        m_val = ((m_val * 2) % (1 << W)) + (rot_on ? (m_val / (1 << (W - 1))) : int'(sl));
        shifted = 1'b1;
      end else if (md == 2'd3) begin
        m_val = int'(p);
        m_cnt = 0;
      end
      if (shifted) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          m_cnt  = 0;
          m_full = 1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_val = 0;
    m_cnt = 0;
    m_full = 0;
  endtask

  // One stimulus cycle: drive at the falling edge, queue the expected result
  task automatic cycle(input bit e, input bit [1:0] md, input bit sr,
                       input bit sl, input bit [W-1:0] p, input bit r);
    @(negedge clk);
    en = e; mode = md; sin_r = sr; sin_l = sl; pin = p; rot = r;
    if (rst) model_step(e, md, sr, sl, p, r);
    else     model_reset();
    exp_q.push_back(model_snapshot());
  endtask

  // Assert reset between edges and check it takes effect without a clock
  task automatic assert_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_pout", int'(pout), 0);
    chk("async_rst_cnt",  int'(cnt),  0);
    chk("async_rst_full", int'(full), 0);
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0; mode = 2'b00;
    exp_q.push_back(model_snapshot());
  endtask

  // Monitor: compare the DUT against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pout",   int'(pout),   int'(e.pout));
        chk("cnt",    int'(cnt),    int'(e.cnt));
        chk("full",   int'(full),   int'(e.full));
        chk("sout_r", int'(sout_r), int'(e.pout[0]));
        chk("sout_l", int'(sout_l), int'(e.pout[W-1]));
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] sipo_bits;
    int full_seen;
    #1;
    chk("init_rst_pout", int'(pout), 0);
    chk("init_rst_cnt",  int'(cnt),  0);
    repeat (2) cycle(1, 2'd3, 1, 1, 8'hFF, 0);
    release_reset();

    // Async reset after loading A5
    cycle(1, 2'd3, 0, 0, 8'hA5, 0);
    assert_reset();
    repeat (2) cycle(1, 2'd1, 1, 1, 8'h5A, 0);
    release_reset();

    // Load then hold, then disabled load
    cycle(1, 2'd3, 0, 0, 8'h3C, 0);
    repeat (3) cycle(1, 2'd0, 1, 1, 8'h00, 0);
    repeat (2) cycle(0, 2'd3, 1, 1, 8'hFF, 0);
    @(posedge clk); #2;
    chk("hold_value", int'(pout), 8'h3C);

    // SIPO right
    sipo_bits = 8'b0100_1101;
    cycle(1, 2'd3, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cycle(1, 2'd1, sipo_bits[i], 0, 8'h00, 0);
    @(posedge clk); #2;
    chk("sipo_word", int'(pout), 8'h4D);
    chk("sipo_full", int'(full), 1);
    cycle(1, 2'd0, 0, 0, 8'h00, 0);

    // PISO left
    cycle(1, 2'd3, 0, 0, 8'h81, 0);
    for (int i = 0; i < 8; i++) cycle(1, 2'd2, 0, 0, 8'h00, 0);
    cycle(1, 2'd0, 0, 0, 8'h00, 0);
    @(posedge clk); #2;
    chk("piso_empty", int'(pout), 8'h00);

    // Interrupted word then a full post-reset word
    cycle(1, 2'd3, 0, 0, 8'hC3, 0);
    for (int i = 0; i < 5; i++) cycle(1, 2'd1, 1, 0, 8'h00, 0);
    assert_reset();
    cycle(1, 2'd1, 1, 1, 8'h00, 0);
    release_reset();
    full_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, (i % 2 == 0) ? 2'd1 : 2'd2, 1, 0, 8'h00, 0);
      @(posedge clk); #2;
      if (full) full_seen++;
      if (i == 7) chk("interrupt_full_8th", int'(full), 1);
    end
    chk("interrupt_pulses", full_seen, 1);

    // Rotate left (shifts zeros in when the rotate option is absent)
    cycle(1, 2'd3, 0, 0, 8'h01, 0);
    for (int i = 0; i < 8; i++) cycle(1, 2'd2, 0, 0, 8'h00, 1);
    @(posedge clk); #2;
`ifdef SHIFT_REG_ROTATE_EN
    chk("rotate_word", int'(pout), 8'h01);
`else
    chk("rotate_word", int'(pout), 8'h00);
`endif

    // Back-to-back words with random data
    for (int i = 0; i < 24; i++) cycle(1, 2'd1, 1'($urandom), 0, 8'h00, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        assert_reset();
        cycle(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        release_reset();
      end else begin
        cycle($urandom_range(0, 9) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 1'($urandom));
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
